// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
//   Shared definitions for the data-memory responder.
//   - MemSize (funct3) encodings SZ_B/SZ_H/SZ_W/SZ_BU/SZ_HU
//   - FSM state enum
//   - be_of():      byte enables for a store of a given size at address bits [1:0]
//   - store_lanes(): store data replicated onto the byte lanes
//   - load_ext():   lane select plus sign/zero extension of a loaded word
// -----------------------------------------------------------------------------
package dm_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } dm_state_e;

  // Little-endian byte enables. Alignment is checked elsewhere, so a halfword
  // only ever sits in lanes 0-1 or 2-3.
  function automatic logic [3:0] be_of(input logic [2:0] size, input logic [1:0] a10);
    case (size)
      SZ_B, SZ_BU: be_of = 4'b0001 << a10;
      SZ_H, SZ_HU: be_of = a10[1] ? 4'b1100 : 4'b0011;
      SZ_W:        be_of = 4'b1111;
      default:     be_of = 4'b0000;
    endcase
  endfunction

  // Replicating the low byte/half across the word lets the byte enables pick
  // the lane without a shifter.
  function automatic logic [31:0] store_lanes(input logic [2:0] size, input logic [31:0] wd);
    case (size[1:0])
      2'b00:   store_lanes = {4{wd[7:0]}};
      2'b01:   store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0]  size,
                                           input logic [1:0]  a10,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {a10, 3'b000};
    case (size)
      SZ_B:    load_ext = {{24{sh[7]}}, sh[7:0]};
      SZ_BU:   load_ext = {24'h0, sh[7:0]};
      SZ_H:    load_ext = {{16{sh[15]}}, sh[15:0]};
      SZ_HU:   load_ext = {16'h0, sh[15:0]};
      SZ_W:    load_ext = word;
      default: load_ext = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dm_word_ram.sv
// -----------------------------------------------------------------------------
// dm_word_ram
//   Single-port synchronous 32-bit word array with per-byte write enables.
//   Ports:
//     clk      clock, rising edge
//     en_i     access strobe for this cycle
//     we_i     1 = write enabled bytes, 0 = read word into rdata_o
//     be_i     byte enables (bit n -> bits 8n+7:8n)
//     addr_i   word index
//     wdata_i  write data (already lane-aligned)
//     rdata_o  read data, registered; holds its value between reads
// -----------------------------------------------------------------------------
module dm_word_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // NOTE: the array and its read register have no reset: clearing a RAM is not
  // possible in one cycle and would prevent mapping onto block memory.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Responder side of the CPU data-memory interface. Each access stalls the CPU
//   for LATENCY+1 cycles (IDLE -> WAIT x LATENCY -> DONE) and returns load data
//   or a fault in the DONE cycle.
//   Parameters:
//     DEPTH_WORDS  words in the array (power of two)
//     LATENCY      wait cycles between capture and response (0..15)
//   Ports:
//     CLK      clock, rising edge
//     RESET    asynchronous, active-low reset
//     MemReq   access request (A/WE/Size/WD stable while Stall=1)
//     MemWE    1 = store, 0 = load
//     MemSize  funct3 size/sign encoding
//     MemA     byte address
//     MemWD    store data
//     MemRD    extended load data, non-zero only in DONE
//     Stall    CPU hold
//     MemErr   one-cycle fault pulse in DONE
//   Build option: define DM_BOUNDS_CHECK_EN to fault addresses >= 4*DEPTH_WORDS;
//   otherwise upper address bits are ignored and accesses wrap.
// -----------------------------------------------------------------------------
module data_mem_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemReq,
  input  logic        MemWE,
  input  logic [2:0]  MemSize,
  input  logic [31:0] MemA,
  input  logic [31:0] MemWD,
  output logic [31:0] MemRD,
  output logic        Stall,
  output logic        MemErr
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_INIT = 4'(LATENCY > 0 ? LATENCY - 1 : 0);

  dm_state_e      state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           capture, access;

  // Captured request
  logic           we_q, oob_q;
  logic [2:0]     size_q;
  logic [AW+1:0]  a_q;
  logic [31:0]    wd_q;

  // Request as seen this cycle: live inputs in IDLE (needed when LATENCY=0
  // captures and accesses on the same edge), captured copy afterwards.
  logic           v_we, v_oob;
  logic [2:0]     v_size;
  logic [AW+1:0]  v_a;
  logic [31:0]    v_wd;

  logic           oob_live, fault;
  logic [31:0]    ram_rdata;

`ifdef DM_BOUNDS_CHECK_EN
  assign oob_live = |MemA[31:AW+2];
`else
  assign oob_live = 1'b0;
  logic unused_hi;
  assign unused_hi = ^MemA[31:AW+2];
`endif

  always_comb begin
    if (state_q == ST_IDLE) begin
      v_we   = MemWE;
      v_size = MemSize;
      v_a    = MemA[AW+1:0];
      v_wd   = MemWD;
      v_oob  = oob_live;
    end else begin
      v_we   = we_q;
      v_size = size_q;
      v_a    = a_q;
      v_wd   = wd_q;
      v_oob  = oob_q;
    end
  end

  // Misaligned halfword/word, reserved encodings, and unsigned-store encodings
  // all fault; a faulting request never touches the array.
  always_comb begin
    fault = v_oob;
    case (v_size)
      SZ_B, SZ_BU: fault = fault | (v_we && v_size[2]);
      SZ_H, SZ_HU: fault = fault | v_a[0] | (v_we && v_size[2]);
      SZ_W:        fault = fault | (v_a[1:0] != 2'b00);
      default:     fault = 1'b1;
    endcase
  end

  // NOTE: every output of a combinational block is assigned a default first so
  // no path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MemReq) begin
          capture = 1'b1;
          if (LATENCY == 0) begin
            access  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d   = LAT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      we_q   <= 1'b0;
      oob_q  <= 1'b0;
      size_q <= 3'b000;
      a_q    <= '0;
      wd_q   <= 32'h0;
    end else if (capture) begin
      we_q   <= MemWE;
      oob_q  <= oob_live;
      size_q <= MemSize;
      a_q    <= MemA[AW+1:0];
      wd_q   <= MemWD;
    end
  end

  // The array access is qualified with RESET so a request held during reset
  // can neither write nor stall the CPU.
  dm_word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk    (CLK),
    .en_i   (access && !fault && RESET),
    .we_i   (v_we),
    .be_i   (be_of(v_size, v_a[1:0])),
    .addr_i (v_a[AW+1:2]),
    .wdata_i(store_lanes(v_size, v_wd)),
    .rdata_o(ram_rdata)
  );

  assign Stall  = RESET && ((state_q == ST_IDLE && MemReq) || state_q == ST_WAIT);
  assign MemErr = (state_q == ST_DONE) && fault;
  assign MemRD  = (state_q == ST_DONE && !fault && !v_we)
                  ? load_ext(v_size, v_a[1:0], ram_rdata) : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Two responders: unit 0 (1024 words, LATENCY=2) and unit 1 (16 words,
//   LATENCY=0). A byte-array reference model predicts load data and faults.
//   Honours DM_BOUNDS_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int NU     = 2;
  localparam int DEPTH0 = 1024;
  localparam int DEPTH1 = 16;
  localparam int LAT0   = 2;
  localparam int LAT1   = 0;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   [NU];
  logic        we    [NU];
  logic [2:0]  sz    [NU];
  logic [31:0] a     [NU];
  logic [31:0] wd    [NU];
  logic [31:0] rd    [NU];
  logic        stall [NU];
  logic        err   [NU];

  int n_tests = 0;
  int n_fail  = 0;
  bit in_done [NU];
  logic [7:0] mdl [NU][4096];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH0), .LATENCY(LAT0)) u_dut0 (
    .CLK(clk), .RESET(rst_n), .MemReq(req[0]), .MemWE(we[0]), .MemSize(sz[0]),
    .MemA(a[0]), .MemWD(wd[0]), .MemRD(rd[0]), .Stall(stall[0]), .MemErr(err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH1), .LATENCY(LAT1)) u_dut1 (
    .CLK(clk), .RESET(rst_n), .MemReq(req[1]), .MemWE(we[1]), .MemSize(sz[1]),
    .MemA(a[1]), .MemWD(wd[1]), .MemRD(rd[1]), .Stall(stall[1]), .MemErr(err[1])
  );

  function automatic int depth_of(input int u);
    return (u == 0) ? DEPTH0 : DEPTH1;
  endfunction

  function automatic int lat_of(input int u);
    return (u == 0) ? LAT0 : LAT1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: what a byte-addressed memory answers for one access.
  task automatic ref_access(input int u, input bit w, input logic [2:0] s,
                            input logic [31:0] addr, input logic [31:0] data,
                            output logic [31:0] exp_rd, output bit exp_err);
    int    nb;
    int    base;
    longint lim;
    logic [31:0] v;
    lim     = 4 * depth_of(u);
    exp_rd  = 32'h0;
    exp_err = 1'b0;
    case (s)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      3'd2:       nb = 4;
      default: begin nb = 1; exp_err = 1'b1; end
    endcase
    if (w && s >= 3'd4) exp_err = 1'b1;
    if (addr % nb != 0) exp_err = 1'b1;
`ifdef DM_BOUNDS_CHECK_EN
    if (longint'(addr) >= lim) exp_err = 1'b1;
`endif
    if (exp_err) return;
    base = int'(longint'(addr) % lim);
    if (w) begin
      for (int i = 0; i < nb; i++) mdl[u][base+i] = data[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[u][base+i];
      if (s < 3'd4 && nb < 4 && v[8*nb-1]) begin
        for (int j = 8*nb; j < 32; j++) v[j] = 1'b1;
      end
      exp_rd = v;
    end
  endtask

  // Called at a falling edge. When the previous access is in DONE, the new
  // request is presented there (as a CPU would) and accepted in the next IDLE.
  task automatic access(input int u, input bit w, input logic [2:0] s,
                        input logic [31:0] addr, input logic [31:0] data,
                        input string tag, output logic [31:0] rd_obs);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          n;
    ref_access(u, w, s, addr, data, exp_rd, exp_err);
    req[u] = 1'b1; we[u] = w; sz[u] = s; a[u] = addr; wd[u] = data;
    if (in_done[u]) @(negedge clk);
    #1;
    n = 0;
    while (stall[u] && n < 40) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("%s_stall_cycles", tag), n, lat_of(u) + 1);
    check($sformatf("%s_rd", tag), rd[u], exp_rd);
    check($sformatf("%s_err", tag), err[u], {31'h0, exp_err});
    rd_obs     = rd[u];
    in_done[u] = 1'b1;
  endtask

  task automatic idle(input int u, input int n);
    req[u] = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("u%0d_idle_stall", u), stall[u], 0);
      check($sformatf("u%0d_idle_err", u), err[u], 0);
      check($sformatf("u%0d_idle_rd", u), rd[u], 0);
    end
    in_done[u] = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [2:0]  s;
    logic [31:0] addr;
    bit          w;
    int          nb, off;

    for (int u = 0; u < NU; u++) begin
      req[u] = 0; we[u] = 0; sz[u] = 0; a[u] = 0; wd[u] = 0; in_done[u] = 0;
    end

    // Reset state, including a request held during reset.
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      check($sformatf("u%0d_rst_stall", u), stall[u], 0);
      check($sformatf("u%0d_rst_err", u), err[u], 0);
      check($sformatf("u%0d_rst_rd", u), rd[u], 0);
    end
    req[0] = 1'b1;
    #1;
    check("rst_req_stall", stall[0], 0);
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Prefill every word the bench will read (back-to-back stores).
    for (int i = 0; i < 64; i++) access(0, 1, 3'd2, i * 4, $urandom, "fill0", r);
    idle(0, 2);
    for (int i = 0; i < DEPTH1; i++) access(1, 1, 3'd2, i * 4, $urandom, "fill1", r);
    idle(1, 2);

    // Word store/load.
    access(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10", r);
    idle(0, 1);
    access(0, 0, 3'd2, 32'h10, 32'h0, "lw10", r);
    check("lw10_const", r, 32'hDEADBEEF);
    idle(0, 1);

    // Byte store, signed and unsigned byte loads.
    access(0, 1, 3'd0, 32'h11, 32'h00000080, "sb11", r);
    access(0, 0, 3'd0, 32'h11, 32'h0, "lb11", r);
    check("lb11_const", r, 32'hFFFFFF80);
    access(0, 0, 3'd4, 32'h11, 32'h0, "lbu11", r);
    check("lbu11_const", r, 32'h00000080);
    access(0, 0, 3'd2, 32'h10, 32'h0, "lw10b", r);
    check("lw10b_const", r, 32'hDEAD80EF);

    // Halfword store/load.
    access(0, 1, 3'd1, 32'h12, 32'hAAAA1234, "sh12", r);
    access(0, 0, 3'd1, 32'h12, 32'h0, "lh12", r);
    check("lh12_const", r, 32'h00001234);
    access(0, 0, 3'd2, 32'h10, 32'h0, "lw10c", r);
    check("lw10c_const", r, 32'h123480EF);
    idle(0, 1);

    // Misalignment faults; the faulting store must not write.
    access(0, 0, 3'd2, 32'h13, 32'h0, "lw13", r);
    check("lw13_err_pulse", err[0], 1);
    idle(0, 1);
    access(0, 1, 3'd1, 32'h11, 32'h0000BEEF, "sh11", r);
    idle(0, 1);
    access(0, 0, 3'd2, 32'h10, 32'h0, "lw10d", r);
    check("lw10d_const", r, 32'h123480EF);
    idle(0, 1);

    // Reset in the middle of WAIT drops the pending store.
    req[0] = 1'b1; we[0] = 1'b1; sz[0] = 3'd2; a[0] = 32'h20; wd[0] = 32'h55;
    @(negedge clk);
    check("rstw_stall_before", stall[0], 1);
    rst_n = 1'b0;
    #1;
    check("rstw_stall_now", stall[0], 0);
    check("rstw_err_now", err[0], 0);
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_done[0] = 1'b0;
    @(negedge clk);
    access(0, 0, 3'd2, 32'h20, 32'h0, "lw20_after_rst", r);
    idle(0, 1);

    // Address beyond the array: fault with bounds checking, wrap without.
    access(0, 1, 3'd2, 32'h1000, 32'hCAFEF00D, "sw1000", r);
    idle(0, 1);
    access(0, 0, 3'd2, 32'h0, 32'h0, "lw0", r);
    idle(0, 1);

    // Zero latency, back-to-back loads and stores.
    access(1, 0, 3'd2, 32'h8, 32'h0, "z_lw8", r);
    access(1, 1, 3'd2, 32'h8, 32'h01234567, "z_sw8", r);
    access(1, 0, 3'd2, 32'h8, 32'h0, "z_lw8b", r);
    check("z_lw8b_const", r, 32'h01234567);
    access(1, 1, 3'd0, 32'hB, 32'h000000F0, "z_sb", r);
    access(1, 0, 3'd0, 32'hB, 32'h0, "z_lb", r);
    check("z_lb_const", r, 32'hFFFFFFF0);
    idle(1, 2);

    // Randomized traffic on both units.
    for (int u = 0; u < NU; u++) begin
      for (int it = 0; it < 250; it++) begin
        if ($urandom_range(0, 9) < 8) begin
          case ($urandom_range(0, 4))
            0: s = 3'd0; 1: s = 3'd1; 2: s = 3'd2; 3: s = 3'd4; default: s = 3'd5;
          endcase
        end else begin
          s = 3'($urandom_range(0, 7));
        end
        w   = 1'($urandom_range(0, 1));
        nb  = 1 << s[1:0];
        off = $urandom_range(0, 3);
        if ($urandom_range(0, 3) != 0 && nb <= 4) off = off - (off % nb);
        addr = 32'($urandom_range(0, (u == 0) ? 63 : DEPTH1 - 1) * 4 + off);
        if ($urandom_range(0, 7) == 0)
          addr = addr | (32'($urandom_range(1, 7)) << ((u == 0) ? 12 : 6));
        access(u, w, s, addr, $urandom, $sformatf("rnd_u%0d", u), r);
        if ($urandom_range(0, 2) == 0) idle(u, $urandom_range(1, 2));
      end
      idle(u, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
